// File: rtl/stage_arb_pkg.sv
// Shared types and the rotate-from-pointer priority search used by the
// round-robin stage arbiter.
package stage_arb_pkg;

    typedef enum logic {ARB, LOCK} arb_state_e;

    localparam int MAX_NREQ = 32;

    // Returns the first set bit of req[nreq-1:0] at or after ptr (wrapping), or -1.
    // Scans from the far end so the lowest rotated offset is the last one written.
    function automatic int rr_select(input logic [MAX_NREQ-1:0] req,
                                     input int nreq,
                                     input int ptr);
        int idx;
        int sel;
        sel = -1;
        for (int k = MAX_NREQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                idx = ptr + k;
                if (idx >= nreq) begin
                    idx = idx - nreq;
                end
                if (req[idx[4:0]]) begin
                    sel = idx;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant, binary index and an
// any-request flag for the first requester at or after the pointer.
module rr_pick
    import stage_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    localparam int SRC_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [SRC_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [SRC_W-1:0] idx,
    output logic             any
);

    logic [MAX_NREQ-1:0] req_wide;
    int                  sel;

    always_comb begin
        req_wide            = '0;
        req_wide[NREQ-1:0]  = req;
        sel                 = rr_select(req_wide, NREQ, int'(ptr));
        any                 = 1'b0;
        grant               = '0;
        idx                 = '0;
        if (sel >= 0) begin
            any        = 1'b1;
            idx        = sel[SRC_W-1:0];
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_stage_arbiter.sv
// Round-robin arbiter sharing one registered pipeline stage between NREQ
// requesters, with per-requester burst lock.
module rr_stage_arbiter
    import stage_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 4,
    localparam int SRC_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_lock,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SRC_W-1:0]      out_src,
    input  logic                  out_ready
);

    if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
        $error("rr_stage_arbiter: NREQ out of range");
    end

    arb_state_e       state, state_next;
    logic [SRC_W-1:0] rr_ptr, rr_ptr_next;
    logic [SRC_W-1:0] lock_owner, lock_owner_next;
    logic [NREQ-1:0]  owner_mask;
    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant;
    logic [SRC_W-1:0] pick_idx;
    logic             pick_any;
    logic             accept;
    logic             transfer;
    logic [WIDTH-1:0] pick_data;

    // During a burst only the owner may be picked, even if it is momentarily idle.
    assign accept     = !out_valid || out_ready;
    assign owner_mask = NREQ'(1) << lock_owner;
    assign eligible   = (state == LOCK) ? (req_valid & owner_mask) : req_valid;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign req_ready = accept ? grant : '0;
    assign transfer  = accept && pick_any;
    assign pick_data = req_data[pick_idx*WIDTH +: WIDTH];

    always_comb begin
        state_next      = state;
        rr_ptr_next     = rr_ptr;
        lock_owner_next = lock_owner;
        if (transfer) begin
            rr_ptr_next = (pick_idx == SRC_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            if (req_lock[pick_idx]) begin
                state_next      = LOCK;
                lock_owner_next = pick_idx;
            end else begin
                state_next = ARB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB;
            rr_ptr     <= '0;
            lock_owner <= '0;
        end else begin
            state      <= state_next;
            rr_ptr     <= rr_ptr_next;
            lock_owner <= lock_owner_next;
        end
    end

    // A new beat overwrites the draining one directly, so streaming has no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= pick_data;
            out_src   <= pick_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));
    a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (req_ready & ~req_valid) == '0);
    a_stall_holds: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_src)));

endmodule

// File: tb/tb_rr_stage_arbiter.sv
// Directed bench for rr_stage_arbiter: expected beats go into a scoreboard queue,
// a negedge monitor pops them whenever the stage hands a beat downstream.
module tb_rr_stage_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int SRC_W = 2;

    typedef struct {
        logic [SRC_W-1:0] src;
        logic [WIDTH-1:0] data;
    } beat_t;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_lock;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SRC_W-1:0]      out_src;
    logic                  out_ready;

    beat_t exp_q[$];
    beat_t mon_beat;
    int    vectors;
    int    miscompares;

    rr_stage_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Called at posedge+1; drives one cycle, queues the beat it expects to be
    // accepted, checks req_ready at negedge and returns at the next posedge+1.
    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] lock,
                                 input logic [NREQ*WIDTH-1:0] data, input logic ordy,
                                 input logic [NREQ-1:0] exp_ready, input logic do_push,
                                 input logic [SRC_W-1:0] exp_src, input logic [WIDTH-1:0] exp_data);
        beat_t b;
        req_valid = valid;
        req_lock  = lock;
        req_data  = data;
        out_ready = ordy;
        if (do_push) begin
            b.src  = exp_src;
            b.data = exp_data;
            exp_q.push_back(b);
        end
        @(negedge clk);
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_beat: got src %0d data %0h, expected no beat at %0t",
                         out_src, out_data, $time);
            end else begin
                mon_beat = exp_q.pop_front();
                checkOutput("out_src", 32'(out_src), 32'(mon_beat.src));
                checkOutput("out_data", 32'(out_data), 32'(mon_beat.data));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = '0;
        req_lock    = '0;
        req_data    = '0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        checkOutput("reset_out_src", 32'(out_src), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;

        $display("[TB] all requesters streaming");
        applyStimulus(4'b1111, 4'b0000, 16'h4321, 1'b1, 4'b0001, 1'b1, 2'd0, 4'h1);
        applyStimulus(4'b1111, 4'b0000, 16'h4321, 1'b1, 4'b0010, 1'b1, 2'd1, 4'h2);
        applyStimulus(4'b1111, 4'b0000, 16'h4321, 1'b1, 4'b0100, 1'b1, 2'd2, 4'h3);
        applyStimulus(4'b1111, 4'b0000, 16'h4321, 1'b1, 4'b1000, 1'b1, 2'd3, 4'h4);
        applyStimulus(4'b1111, 4'b0000, 16'h4321, 1'b1, 4'b0001, 1'b1, 2'd0, 4'h1);

        $display("[TB] requesters 0 and 2 alternating");
        applyStimulus(4'b0101, 4'b0000, 16'h0A03, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hA);
        applyStimulus(4'b0101, 4'b0000, 16'h0A03, 1'b1, 4'b0001, 1'b1, 2'd0, 4'h3);
        applyStimulus(4'b0101, 4'b0000, 16'h0A03, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hA);
        applyStimulus(4'b0101, 4'b0000, 16'h0A03, 1'b1, 4'b0001, 1'b1, 2'd0, 4'h3);

        $display("[TB] locked burst from requester 1");
        applyStimulus(4'b0111, 4'b0010, 16'h0785, 1'b1, 4'b0010, 1'b1, 2'd1, 4'h8);
        applyStimulus(4'b0111, 4'b0010, 16'h0795, 1'b1, 4'b0010, 1'b1, 2'd1, 4'h9);
        applyStimulus(4'b0111, 4'b0000, 16'h07A5, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hA);
        applyStimulus(4'b0101, 4'b0000, 16'h07A5, 1'b1, 4'b0100, 1'b1, 2'd2, 4'h7);

        $display("[TB] five-cycle stall");
        applyStimulus(4'b1111, 4'b0000, 16'hB705, 1'b0, 4'b0000, 1'b0, 2'd0, 4'h0);
        applyStimulus(4'b0001, 4'b0000, 16'hB705, 1'b0, 4'b0000, 1'b0, 2'd0, 4'h0);
        applyStimulus(4'b1000, 4'b0000, 16'hB705, 1'b0, 4'b0000, 1'b0, 2'd0, 4'h0);
        applyStimulus(4'b0110, 4'b0000, 16'hB705, 1'b0, 4'b0000, 1'b0, 2'd0, 4'h0);
        applyStimulus(4'b1111, 4'b0000, 16'hB705, 1'b0, 4'b0000, 1'b0, 2'd0, 4'h0);
        checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_out_src", 32'(out_src), 32'd2);
        checkOutput("stall_out_data", 32'(out_data), 32'h7);
        applyStimulus(4'b1111, 4'b0000, 16'hB705, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hB);
        applyStimulus(4'b0000, 4'b0000, 16'hB705, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0);

        $display("[TB] reset during a held locked beat");
        applyStimulus(4'b0010, 4'b0010, 16'hEFCD, 1'b0, 4'b0010, 1'b0, 2'd0, 4'h0);
        applyStimulus(4'b0010, 4'b0010, 16'hEFCD, 1'b0, 4'b0000, 1'b0, 2'd0, 4'h0);
        checkOutput("prereset_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_out_data", 32'(out_data), 32'd0);
        checkOutput("async_out_src", 32'(out_src), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(4'b1111, 4'b0000, 16'hEFCD, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hD);

        $display("[TB] lock owner 2 pauses mid-burst");
        applyStimulus(4'b0100, 4'b0100, 16'h8176, 1'b1, 4'b0100, 1'b1, 2'd2, 4'h1);
        applyStimulus(4'b1011, 4'b0000, 16'h8276, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0);
        applyStimulus(4'b1011, 4'b0000, 16'h8276, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0);
        applyStimulus(4'b1011, 4'b0000, 16'h8276, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0);
        applyStimulus(4'b1111, 4'b0100, 16'h8276, 1'b1, 4'b0100, 1'b1, 2'd2, 4'h2);
        applyStimulus(4'b1111, 4'b0000, 16'h8376, 1'b1, 4'b0100, 1'b1, 2'd2, 4'h3);
        applyStimulus(4'b1111, 4'b0000, 16'h8376, 1'b1, 4'b1000, 1'b1, 2'd3, 4'h8);
        applyStimulus(4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0);
        applyStimulus(4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
